// File: rtl/streaming_reorder_collector.sv
// streaming_reorder_collector
// Tags each accepted input with a reorder slot, takes results back from
// NUM_CHANNELS cores in any order, and re-emits them in allocation order
// together with the sideband captured at input.
// Optional head-of-line watchdog: define REORDER_TIMEOUT_EN.
//
// Handshake: there is no ready. isBotValid is accepted whenever a slot is
// free (or the head retires that same cycle), otherwise it is dropped and
// overflowError sets. chResultValid[i] is a one-cycle strobe. issueValid and
// resultValid are one-cycle strobes with no downstream stall.
module streaming_reorder_collector #(
    parameter int NUM_CHANNELS       = 4,
    parameter int RESULT_WIDTH       = 6,
    parameter int EXTRA_DATA_WIDTH   = 1,
    parameter int DEPTH_LOG2         = 6,
    parameter int ALMOST_FULL_MARGIN = 4
`ifdef REORDER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES     = 1024
`endif
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 isBotValid,
    input  logic [EXTRA_DATA_WIDTH-1:0]          extraDataIn,
    output logic                                 slowDownInput,
    output logic                                 issueValid,
    output logic [DEPTH_LOG2-1:0]                issueTag,
    input  logic [NUM_CHANNELS-1:0]              chResultValid,
    input  logic [NUM_CHANNELS*DEPTH_LOG2-1:0]   chResultTag,
    input  logic [NUM_CHANNELS*RESULT_WIDTH-1:0] chResultCount,
    output logic                                 resultValid,
    output logic [RESULT_WIDTH-1:0]              connectCount,
    output logic [EXTRA_DATA_WIDTH-1:0]          extraDataOut,
    output logic [DEPTH_LOG2:0]                  occupancy,
    output logic                                 overflowError,
    output logic                                 protocolError,
    output logic                                 timeoutError
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] L_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] L_THR   = (DEPTH_LOG2+1)'(DEPTH - ALMOST_FULL_MARGIN);

    logic [DEPTH_LOG2-1:0]       r_wr_ptr;
    logic [DEPTH_LOG2-1:0]       r_rd_ptr;
    logic [DEPTH-1:0]            r_pending;
    logic [DEPTH-1:0]            r_done;
    logic [DEPTH_LOG2:0]         r_occ;
    logic [RESULT_WIDTH-1:0]     r_count [DEPTH];
    logic [EXTRA_DATA_WIDTH-1:0] r_extra [DEPTH];

    logic                        w_full;
    logic                        w_retire;
    logic                        w_alloc;
    logic                        w_overflow;
    logic [DEPTH_LOG2:0]         w_occ_next;
    logic [DEPTH_LOG2-1:0]       w_tag [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]     w_acc;
    logic [DEPTH-1:0]            w_claim;
    logic                        w_proto;

    // Allocation/retire decisions; a retiring head frees its slot for a same-cycle alloc
    always_comb begin
        w_full     = (r_occ == L_DEPTH);
        w_retire   = r_pending[r_rd_ptr] && r_done[r_rd_ptr];
        w_alloc    = isBotValid && (!w_full || w_retire);
        w_overflow = isBotValid && w_full && !w_retire;
        w_occ_next = r_occ + (DEPTH_LOG2+1)'(w_alloc) - (DEPTH_LOG2+1)'(w_retire);
    end

    // Per-channel result decode; lowest channel index claims a slot first
    always_comb begin
        w_acc   = '0;
        w_claim = '0;
        w_proto = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_tag[i] = chResultTag[i*DEPTH_LOG2 +: DEPTH_LOG2];
            if (chResultValid[i]) begin
                if (r_pending[w_tag[i]] && !r_done[w_tag[i]] && !w_claim[w_tag[i]]) begin
                    w_claim[w_tag[i]] = 1'b1;
                    w_acc[i]          = 1'b1;
                end else begin
                    w_proto = 1'b1;
                end
            end
        end
    end

    // Control state, status flags and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_pending     <= '0;
            r_done        <= '0;
            r_occ         <= '0;
            slowDownInput <= 1'b0;
            issueValid    <= 1'b0;
            issueTag      <= '0;
            resultValid   <= 1'b0;
            connectCount  <= '0;
            extraDataOut  <= '0;
            overflowError <= 1'b0;
            protocolError <= 1'b0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (w_claim[s]) r_done[s] <= 1'b1;
            end
            if (w_retire) begin
                r_pending[r_rd_ptr] <= 1'b0;
                r_done[r_rd_ptr]    <= 1'b0;
                r_rd_ptr            <= r_rd_ptr + 1'b1;
                connectCount        <= r_count[r_rd_ptr];
                extraDataOut        <= r_extra[r_rd_ptr];
            end
            // Placed after the retire clear: when full, wr_ptr equals rd_ptr
            if (w_alloc) begin
                r_pending[r_wr_ptr] <= 1'b1;
                r_done[r_wr_ptr]    <= 1'b0;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
                issueTag            <= r_wr_ptr;
            end
            issueValid    <= w_alloc;
            resultValid   <= w_retire;
            r_occ         <= w_occ_next;
            slowDownInput <= (w_occ_next >= L_THR);
            if (w_overflow) overflowError <= 1'b1;
            if (w_proto)    protocolError <= 1'b1;
        end
    end

    // Slot payload storage; contents survive reset by design
    always_ff @(posedge clk) begin
        if (w_alloc) r_extra[r_wr_ptr] <= extraDataIn;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_acc[i]) r_count[w_tag[i]] <= chResultCount[i*RESULT_WIDTH +: RESULT_WIDTH];
        end
    end

    assign occupancy = r_occ;

`ifdef REORDER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    // Head-of-line watchdog: counts cycles the head waits for its result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_retire || (r_occ == '0)) begin
                r_to_cnt <= '0;
            end else if (r_pending[r_rd_ptr] && !r_done[r_rd_ptr] &&
                         (r_to_cnt != TO_W'(TIMEOUT_CYCLES))) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (r_to_cnt == TO_W'(TIMEOUT_CYCLES)) r_timeout <= 1'b1;
        end
    end

    assign timeoutError = r_timeout;
`else
    assign timeoutError = 1'b0;
`endif

endmodule
